amux_scan_seq: RTL and testbench
================================

AMUX_SCAN_SEQ -- requirements
Module: amux_scan_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8, clocks the mux output settles between a SEL change and the ADC start.
REQ-002 SHALL have parameter ADC_W, default 10, ADC result width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum clocks to wait for adc_done.
REQ-004 SHALL have ports in this order, starting with clock and reset:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  block enable.
- start  in  1  one-cycle request to begin a scan round.
- continuous  in  1  restart rounds automatically while set.
- ch_mask  in  4  channels to scan; bit n selects AIN(n+1).
- sel  out  2  drives the 4:1 analog mux select.
- adc_start  out  1  one-cycle conversion request.
- adc_done  in  1  one-cycle conversion-complete strobe.
- adc_data  in  ADC_W  conversion result, valid with adc_done.
- rd_ch  in  2  result read index.
- rd_data  out  ADC_W  stored result for rd_ch (combinational read).
- valid  out  4  per-channel result-valid flags.
- timeout_err  out  4  per-channel sticky timeout flags.
- busy  out  1  high in any state other than IDLE.
- round_done  out  1  one-cycle pulse at the end of each round.

Function
REQ-005 SHALL implement the states IDLE, SETTLE, CONVERT, WAIT and NEXT.
REQ-006 IDLE SHALL go to SETTLE when start=1, enable=1 and ch_mask!=0; at that edge it SHALL latch ch_mask into an active mask and set sel to the lowest set bit.
REQ-007 When start arrives with ch_mask==0, the block SHALL ignore it and stay in IDLE.
REQ-008 SETTLE SHALL count exactly SETTLE_CYCLES clocks, then enter CONVERT; sel SHALL be stable throughout.
REQ-009 CONVERT SHALL assert adc_start for exactly one cycle, then enter WAIT.
REQ-010 In WAIT, adc_done=1 SHALL write adc_data to result[sel], set valid[sel], clear timeout_err[sel] and go to NEXT.
REQ-011 In WAIT, if TIMEOUT_CYCLES clocks pass without adc_done, the block SHALL set timeout_err[sel], leave result and valid unchanged, and go to NEXT.
REQ-012 adc_done outside WAIT SHALL be ignored.
REQ-013 NEXT SHALL select the next higher set bit of the active mask and go to SETTLE; with no higher bit, it SHALL pulse round_done.
REQ-014 After that round_done pulse, the block SHALL return to IDLE, or, when continuous=1, re-latch ch_mask and restart at its lowest set bit. A zero re-latched mask SHALL go to IDLE.
REQ-015 Changes to ch_mask during a round SHALL take effect only at the next round start.
REQ-016 enable=0 in any non-IDLE state SHALL abort to IDLE on the next edge; no result is written and sel holds its value.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 rd_data SHALL equal result[rd_ch] combinationally; a same-cycle write is visible on the following cycle.

Reset
REQ-019 reset SHALL asynchronously force:
- state to IDLE
- sel=2'b00, adc_start=0, busy=0, round_done=0
- valid=0, timeout_err=0
- all results and counters to 0

Configuration
REQ-020 With AMUX_SCAN_IRQ_EN defined, the block SHALL add an output irq (1 bit) and an input irq_clr (1 bit).
REQ-021 irq SHALL set on round_done or on any new timeout_err bit, and clear on irq_clr; a set event wins over a simultaneous irq_clr. Reset value of irq is 0.
REQ-022 Without AMUX_SCAN_IRQ_EN, the irq and irq_clr ports and their logic SHALL be absent.

Structure
REQ-023 A shared package amux_scan_pkg SHALL hold the state enum type, the channel count constant (4) and the select width constant (2).
REQ-024 The next-channel priority search SHALL be a sub-module amux_scan_nextch: inputs are the mask and current index; outputs are the next index and a found flag.

Verification
REQ-025 Bench SHALL cover the following directed scenarios:
- ch_mask=4'b1010, start, adc_done after 3 cycles with data 0x155 then 0x2AA -> sel=1 then 3; result[1]=0x155, result[3]=0x2AA; valid=4'b1010; one round_done.
- SETTLE_CYCLES=8 -> adc_start occurs exactly 8 clocks after the sel change.
- ch_mask=4'b0001, adc_done never asserted -> timeout_err=4'b0001 after 255 WAIT cycles; valid[0]=0; round_done pulses.
- continuous=1, ch_mask=4'b1111 -> sel cycles 0,1,2,3,0,...; round_done every round; clearing continuous ends at the current round end.
- enable dropped during WAIT -> IDLE next cycle; a later adc_done is ignored; valid is unchanged.
- reset asserted mid-SETTLE without a clock edge -> all outputs at reset values immediately.

Source files
------------

// File: rtl/amux_scan_pkg.sv
// Shared types and constants for the analog-mux scan sequencer.
package amux_scan_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StConvert,
        StWait,
        StNext
    } scan_state_e;

    // Index of the lowest set bit of a channel mask (0 for an empty mask).
    function automatic logic [SEL_W-1:0] lowest_ch(input logic [CH_NUM-1:0] mask);
        lowest_ch = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i]) lowest_ch = SEL_W'(i);
        end
    endfunction

endpackage

// File: rtl/amux_scan_nextch.sv
// Priority search: next set bit of the mask strictly above the current index.
module amux_scan_nextch
    import amux_scan_pkg::*;
(
    input  logic [CH_NUM-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next_ch,
    output logic              found
);

    // Scan downwards so the lowest qualifying bit is the one left standing.
    always_comb begin
        next_ch = cur;
        found   = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next_ch = SEL_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/amux_scan_seq.sv
// Analog-mux scan sequencer: walks the masked channels, settles the mux,
// kicks the ADC, stores each result and flags per-channel timeouts.
// Optional feature: define AMUX_SCAN_IRQ_EN to add the irq / irq_clr ports.
module amux_scan_seq
    import amux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 8,
    parameter int ADC_W          = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic               continuous,
    input  logic [CH_NUM-1:0]  ch_mask,
    output logic [SEL_W-1:0]   sel,
    output logic               adc_start,
    input  logic               adc_done,
    input  logic [ADC_W-1:0]   adc_data,
    input  logic [SEL_W-1:0]   rd_ch,
    output logic [ADC_W-1:0]   rd_data,
    output logic [CH_NUM-1:0]  valid,
    output logic [CH_NUM-1:0]  timeout_err,
    output logic               busy,
    output logic               round_done
`ifdef AMUX_SCAN_IRQ_EN
    ,
    input  logic               irq_clr,
    output logic               irq
`endif
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    scan_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_NUM-1:0]  mask_q, mask_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADC_W-1:0]   result_q [CH_NUM];
    logic               wr_en, to_set;
    logic [SEL_W-1:0]   nxt_ch;
    logic               nxt_found;

    amux_scan_nextch u_nextch (
        .mask    (mask_q),
        .cur     (sel_q),
        .next_ch (nxt_ch),
        .found   (nxt_found)
    );

    // Moore outputs decoded from the current state.
    assign sel        = sel_q;
    assign busy       = (state_q != StIdle);
    assign adc_start  = (state_q == StConvert);
    assign round_done = (state_q == StNext) && !nxt_found;
    assign rd_data    = result_q[rd_ch];

    // Next-state logic; a dropped enable overrides every non-idle transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        wr_en   = 1'b0;
        to_set  = 1'b0;
        if ((state_q != StIdle) && !enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && enable && (ch_mask != '0)) begin
                        state_d = StSettle;
                        mask_d  = ch_mask;
                        sel_d   = lowest_ch(ch_mask);
                        cnt_d   = '0;
                    end
                end
                StSettle: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = StConvert;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StConvert: begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
                StWait: begin
                    if (adc_done) begin
                        wr_en   = 1'b1;
                        state_d = StNext;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        to_set  = 1'b1;
                        state_d = StNext;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StNext: begin
                    cnt_d = '0;
                    if (nxt_found) begin
                        sel_d   = nxt_ch;
                        state_d = StSettle;
                    end else if (continuous && (ch_mask != '0)) begin
                        mask_d  = ch_mask;
                        sel_d   = lowest_ch(ch_mask);
                        state_d = StSettle;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Sequencer state, counter, latched mask and mux select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
        end
    end

    // Result store with per-channel valid and sticky timeout flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH_NUM; i++) result_q[i] <= '0;
            valid       <= '0;
            timeout_err <= '0;
        end else if (wr_en) begin
            result_q[sel_q]    <= adc_data;
            valid[sel_q]       <= 1'b1;
            timeout_err[sel_q] <= 1'b0;
        end else if (to_set) begin
            timeout_err[sel_q] <= 1'b1;
        end
    end

`ifdef AMUX_SCAN_IRQ_EN
    logic irq_q;
    logic irq_set;

    assign irq_set = round_done || (to_set && !timeout_err[sel_q]);
    assign irq     = irq_q;

    // Interrupt latch; a new event beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_amux_scan_seq.sv
// Self-checking bench for amux_scan_seq (default build, irq feature off).
module tb_amux_scan_seq;

    localparam int SETTLE = 8;
    localparam int TMO    = 255;

    logic       clk = 1'b0;
    logic       reset, enable, start, continuous;
    logic [3:0] ch_mask;
    logic [1:0] sel;
    logic       adc_start, adc_done;
    logic [9:0] adc_data;
    logic [1:0] rd_ch;
    logic [9:0] rd_data;
    logic [3:0] valid, timeout_err;
    logic       busy, round_done;

    amux_scan_seq #(
        .SETTLE_CYCLES  (SETTLE),
        .ADC_W          (10),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .continuous  (continuous),
        .ch_mask     (ch_mask),
        .sel         (sel),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .valid       (valid),
        .timeout_err (timeout_err),
        .busy        (busy),
        .round_done  (round_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: what each channel should hold after the rounds so far.
    logic [9:0] m_result [4];
    logic [3:0] m_valid, m_to;
    logic [9:0] fix_data [4];
    int         dut_rounds = 0;

    always @(negedge clk) if (round_done) dut_rounds++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_result[i] = '0;
        m_valid = '0;
        m_to    = '0;
    endtask

    task automatic check_model();
        check_eq("valid", valid, m_valid);
        check_eq("timeout_err", timeout_err, m_to);
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            #1;
            check_eq($sformatf("rd_data%0d", i), rd_data, m_result[i]);
        end
    endtask

    // Counts negedges until adc_start is seen; -1 if it never comes.
    task automatic wait_adc(output int lat);
        lat = 0;
        forever begin
            tick();
            lat++;
            if (adc_start) break;
            if (lat > 400) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic kick(input logic [3:0] m);
        ch_mask = m;
        start   = 1'b1;
    endtask

    // Serves one round as the ADC. mode 0: random data/timeouts with mask and
    // start scrambling; 1: fixed data, reply 3 cycles after adc_start;
    // 2: never reply; 3: random data, always reply.
    task automatic serve_round(input logic [3:0] m, input int mode, input logic cont_after);
        int         lat, d;
        bit         first, timed;
        logic [9:0] dat;
        logic [3:0] left;
        first = 1'b1;
        left  = m;
        for (int ch = 0; ch < 4; ch++) begin
            if (!m[ch]) continue;
            left[ch] = 1'b0;
            wait_adc(lat);
            check_eq("start_latency", lat, SETTLE + 1);
            check_eq("sel_order", sel, ch);
            if (first) begin
                continuous = cont_after;
                if (mode == 0) begin
                    ch_mask = 4'($urandom);
                    start   = 1'($urandom_range(1));
                end
                first = 1'b0;
            end
            tick();
            check_eq("adc_start_width", adc_start, 0);
            timed = (mode == 2) || ((mode == 0) && ($urandom_range(7) == 0));
            if (timed) begin
                repeat (TMO) tick();
                m_to[ch] = 1'b1;
            end else begin
                d   = (mode == 1) ? 2 : $urandom_range(5);
                dat = (mode == 1) ? fix_data[ch] : 10'($urandom);
                repeat (d) tick();
                adc_done = 1'b1;
                adc_data = dat;
                tick();
                adc_done = 1'b0;
                adc_data = 10'($urandom);
                m_result[ch] = dat;
                m_valid[ch]  = 1'b1;
                m_to[ch]     = 1'b0;
            end
            check_eq("round_done", round_done, (left == 4'b0) ? 1 : 0);
        end
        check_model();
    endtask

    initial begin
        int         r0, lat;
        logic [3:0] cur, v0;
        reset = 1'b1; enable = 1'b1; start = 1'b0; continuous = 1'b0; ch_mask = '0;
        adc_done = 1'b0; adc_data = '0; rd_ch = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sel", sel, 0);
        check_eq("rst_adc_start", adc_start, 0);
        check_eq("rst_round_done", round_done, 0);
        check_model();
        reset = 1'b0;
        tick();

        // Two-channel round with known data.
        fix_data[1] = 10'h155;
        fix_data[3] = 10'h2AA;
        r0 = dut_rounds;
        kick(4'b1010);
        serve_round(4'b1010, 1, 1'b0);
        tick();
        check_eq("a_idle", busy, 0);
        check_eq("a_rounds", dut_rounds - r0, 1);

        // Single channel, ADC never answers.
        r0 = dut_rounds;
        kick(4'b0001);
        serve_round(4'b0001, 2, 1'b0);
        tick();
        check_eq("b_rounds", dut_rounds - r0, 1);

        // Empty mask start is ignored.
        kick(4'b0000);
        tick();
        check_eq("zero_mask_busy", busy, 0);

        // Continuous rounds over all channels, stopped during the third round.
        r0 = dut_rounds;
        continuous = 1'b1;
        kick(4'b1111);
        for (int r = 0; r < 3; r++) serve_round(4'b1111, 3, (r < 2) ? 1'b1 : 1'b0);
        tick();
        check_eq("cont_idle", busy, 0);
        check_eq("cont_rounds", dut_rounds - r0, 3);

        // Enable dropped during WAIT; a late adc_done and a busy start are ignored.
        v0 = m_valid;
        kick(4'b0100);
        wait_adc(lat);
        check_eq("en_latency", lat, SETTLE + 1);
        tick();
        start   = 1'b1;
        ch_mask = 4'b0001;
        enable  = 1'b0;
        tick();
        check_eq("en_abort_busy", busy, 0);
        check_eq("en_abort_sel", sel, 2);
        adc_done = 1'b1;
        adc_data = 10'h3C3;
        tick();
        adc_done = 1'b0;
        check_eq("en_valid_held", valid, v0);
        check_model();
        enable = 1'b1;
        tick();

        // Randomized rounds, some continuous, some with timeouts.
        for (int it = 0; it < 12; it++) begin
            cur = 4'($urandom);
            r0  = dut_rounds;
            kick(cur);
            if (cur == 4'b0) begin
                tick();
                check_eq("rand_zero_busy", busy, 0);
                continue;
            end
            for (int r = 0; r < 8; r++) begin
                serve_round(cur, 0, (r < 3) ? 1'($urandom_range(1)) : 1'b0);
                if (!(continuous && (ch_mask != 4'b0))) begin
                    check_eq("rand_rounds", dut_rounds - r0, r + 1);
                    break;
                end
                cur = ch_mask;
            end
            tick();
            check_eq("rand_idle", busy, 0);
            continuous = 1'b0;
        end

        // Asynchronous reset in the middle of SETTLE.
        kick(4'b0100);
        repeat (3) tick();
        check_eq("pre_rst_sel", sel, 2);
        rd_ch = 2'd1;
        #2 reset = 1'b1;
        #1;
        check_eq("async_busy", busy, 0);
        check_eq("async_sel", sel, 0);
        check_eq("async_adc_start", adc_start, 0);
        check_eq("async_round_done", round_done, 0);
        check_eq("async_valid", valid, 0);
        check_eq("async_timeout", timeout_err, 0);
        check_eq("async_rd_data", rd_data, 0);
        model_clear();
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
